// File: rtl/mem_march_checker_if.sv
// Bundle of RAM-side and control/status signals for mem_march_checker.
// The master modport is the checker; the slave modport is the RAM plus the controlling bench.
interface mem_march_checker_if #(
  parameter int LEN = 256,
  parameter int DW  = 8
);
  localparam int AW = $clog2(LEN);
  localparam int CW = $clog2(2 * LEN + 1);

  logic          start;
  logic [AW-1:0] addr;
  logic [DW-1:0] d;
  logic          wr;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] fail_addr;

  modport master (
    input  start, q,
    output addr, d, wr, busy, done, pass, err_cnt, fail_addr
  );

  modport slave (
    output start, q,
    input  addr, d, wr, busy, done, pass, err_cnt, fail_addr
  );
endinterface

// File: rtl/mem_march_checker.sv
// March driver/checker for a single-port RAM with 1-cycle registered read:
// write P, read P, write ~P, read ~P over every address, then report results.
module mem_march_checker #(
  parameter int LEN = 256,
  parameter int DW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_march_checker_if.master  bus
);
  localparam int AW = $clog2(LEN);
  localparam int CW = $clog2(2 * LEN + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_P,
    RD_P,
    WR_N,
    RD_N,
    FLUSH,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] errCnt_q, errCnt_d;
  logic [AW-1:0] failAddr_q, failAddr_d;
  logic          cmpValid_q, cmpValid_d;
  logic [AW-1:0] cmpAddr_q, cmpAddr_d;
  logic [DW-1:0] cmpExp_q, cmpExp_d;

  logic          mismatch;
  logic [CW-1:0] errAfter;
  logic [AW-1:0] failAfter;
  logic          lastAddr;
  logic [AW-1:0] addrInc;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  assign mismatch = cmpValid_q && (bus.q != cmpExp_q);
  assign lastAddr = (addr_q == LAST_ADDR);
  assign addrInc  = addr_q + AW'(1);

  // Compare result of the read issued last cycle, independent of the current phase.
  always_comb begin
    errAfter  = errCnt_q;
    failAfter = failAddr_q;
    if (mismatch) begin
      if (errCnt_q != '1) errAfter = errCnt_q + CW'(1);
      if (errCnt_q == '0) failAfter = cmpAddr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = '0;
    wr_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    errCnt_d   = errAfter;
    failAddr_d = failAfter;
    cmpValid_d = 1'b0;
    cmpAddr_d  = cmpAddr_q;
    cmpExp_d   = cmpExp_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = WR_P;
          addr_d     = '0;
          wr_d       = 1'b1;
          wdata_d    = pat('0);
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          errCnt_d   = '0;
          failAddr_d = '0;
        end
      end
      WR_P: begin
        if (lastAddr) begin
          state_d = RD_P;
          addr_d  = '0;
        end else begin
          addr_d  = addrInc;
          wr_d    = 1'b1;
          wdata_d = pat(addrInc);
        end
      end
      RD_P: begin
        cmpValid_d = 1'b1;
        cmpAddr_d  = addr_q;
        cmpExp_d   = pat(addr_q);
        if (lastAddr) begin
          state_d = WR_N;
          addr_d  = '0;
          wr_d    = 1'b1;
          wdata_d = ~pat('0);
        end else begin
          addr_d = addrInc;
        end
      end
      WR_N: begin
        if (lastAddr) begin
          state_d = RD_N;
          addr_d  = '0;
        end else begin
          addr_d  = addrInc;
          wr_d    = 1'b1;
          wdata_d = ~pat(addrInc);
        end
      end
      RD_N: begin
        cmpValid_d = 1'b1;
        cmpAddr_d  = addr_q;
        cmpExp_d   = ~pat(addr_q);
        if (lastAddr) begin
          state_d = FLUSH;
          addr_d  = '0;
        end else begin
          addr_d = addrInc;
        end
      end
      FLUSH: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (errAfter == '0);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCnt_q   <= '0;
      failAddr_q <= '0;
      cmpValid_q <= 1'b0;
      cmpAddr_q  <= '0;
      cmpExp_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      errCnt_q   <= errCnt_d;
      failAddr_q <= failAddr_d;
      cmpValid_q <= cmpValid_d;
      cmpAddr_q  <= cmpAddr_d;
      cmpExp_q   <= cmpExp_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.d         = wdata_q;
  assign bus.wr        = wr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = errCnt_q;
  assign bus.fail_addr = failAddr_q;
endmodule

// File: tb/tb_mem_march_checker.sv
// Bench for mem_march_checker: two instances (64x8 and 48x4) each driving a behavioural RAM
// with read-data fault injection; results are predicted by replaying the march reads directly.
module tb_mem_march_checker;
  localparam int LEN_A = 64;
  localparam int DW_A  = 8;
  localparam int LEN_B = 48;
  localparam int DW_B  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_march_checker_if #(.LEN(LEN_A), .DW(DW_A)) ifA ();
  mem_march_checker_if #(.LEN(LEN_B), .DW(DW_B)) ifB ();

  mem_march_checker #(.LEN(LEN_A), .DW(DW_A)) dutA (.clk(clk), .rst(rst), .bus(ifA.master));
  mem_march_checker #(.LEN(LEN_B), .DW(DW_B)) dutB (.clk(clk), .rst(rst), .bus(ifB.master));

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;
  int tStartA     = -100000;
  int tStartB     = -100000;

  logic [7:0] memA  [LEN_A];
  logic [3:0] memB  [LEN_B];
  logic [7:0] maskP [LEN_A];
  logic [7:0] maskN [LEN_A];
  logic       stuck0;
  logic [7:0] qA;
  logic [3:0] qB;

  assign ifA.q = qA;
  assign ifB.q = qB;

  always @(posedge clk) cycle <= cycle + 1;

  // RAM A: registered read returning old data on read-during-write; faults keyed on march cycle.
  always @(posedge clk) begin : ramA
    int k;
    logic [7:0] rd;
    k  = cycle - tStartA;
    rd = memA[ifA.addr];
    if (k >= LEN_A + 1 && k <= 2 * LEN_A) rd = rd ^ maskP[k - LEN_A - 1];
    else if (k >= 3 * LEN_A + 1 && k <= 4 * LEN_A) rd = rd ^ maskN[k - 3 * LEN_A - 1];
    if (stuck0) rd[0] = 1'b0;
    if (ifA.wr) memA[ifA.addr] <= ifA.d;
    qA <= rd;
  end

  always @(posedge clk) begin : ramB
    logic [3:0] rd;
    rd = memB[ifB.addr];
    if (ifB.wr) memB[ifB.addr] <= ifB.d;
    qB <= rd;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sampleOutputs(input int which, output logic [63:0] oAddr, output logic [63:0] oD,
                               output logic [63:0] oWr, output logic [63:0] oBusy,
                               output logic [63:0] oDone, output logic [63:0] oPass,
                               output logic [63:0] oErr, output logic [63:0] oFail);
    if (which == 0) begin
      oAddr = 64'(ifA.addr); oD = 64'(ifA.d); oWr = 64'(ifA.wr); oBusy = 64'(ifA.busy);
      oDone = 64'(ifA.done); oPass = 64'(ifA.pass); oErr = 64'(ifA.err_cnt); oFail = 64'(ifA.fail_addr);
    end else begin
      oAddr = 64'(ifB.addr); oD = 64'(ifB.d); oWr = 64'(ifB.wr); oBusy = 64'(ifB.busy);
      oDone = 64'(ifB.done); oPass = 64'(ifB.pass); oErr = 64'(ifB.err_cnt); oFail = 64'(ifB.fail_addr);
    end
  endtask

  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 0) begin ifA.start = 1'b1; tStartA = cycle; end
    else begin ifB.start = 1'b1; tStartB = cycle; end
    @(negedge clk);
    ifA.start = 1'b0;
    ifB.start = 1'b0;
  endtask

  task automatic clearFaults();
    for (int i = 0; i < LEN_A; i++) begin maskP[i] = 8'h00; maskN[i] = 8'h00; end
    stuck0 = 1'b0;
  endtask

  // Replays every march read on a healthy RAM and applies the injected faults to predict results.
  task automatic modelResults(input int which, output int cnt, output int first);
    int len, m, expV, got;
    len   = (which == 0) ? LEN_A : LEN_B;
    m     = (which == 0) ? 255 : 15;
    cnt   = 0;
    first = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < len; a++) begin
        expV = (ph == 0) ? (a & m) : (~a & m);
        got  = expV;
        if (which == 0) begin
          got = got ^ int'((ph == 0) ? maskP[a] : maskN[a]);
          if (stuck0) got = got & ~1;
        end
        if (got != expV) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
    end
  endtask

  task automatic runMarch(input int which, input int extraStart, input string name);
    int len, m, eCnt, eFirst, ph, a, expD;
    logic [63:0] oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail;
    len = (which == 0) ? LEN_A : LEN_B;
    m   = (which == 0) ? 255 : 15;
    modelResults(which, eCnt, eFirst);
    applyStimulus(which);
    for (int k = 1; k <= 4 * len + 3; k++) begin
      if (which == 0) ifA.start = (k == extraStart);
      else ifB.start = (k == extraStart);
      sampleOutputs(which, oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail);
      if (k <= 4 * len) begin
        ph   = (k - 1) / len;
        a    = (k - 1) % len;
        expD = (ph == 0) ? (a & m) : ((ph == 2) ? (~a & m) : 0);
        checkOutput({name, ".addr"}, oAddr, 64'(a));
        checkOutput({name, ".wr"}, oWr, 64'((ph % 2) == 0));
        checkOutput({name, ".d"}, oD, 64'(expD));
      end else if (k == 4 * len + 1) begin
        checkOutput({name, ".flushWr"}, oWr, 64'(0));
      end
      checkOutput({name, ".busy"}, oBusy, 64'(k <= 4 * len + 1));
      checkOutput({name, ".done"}, oDone, 64'(k == 4 * len + 2));
      if (k >= 4 * len + 2) begin
        checkOutput({name, ".pass"}, oPass, 64'(eCnt == 0));
        checkOutput({name, ".errCnt"}, oErr, 64'(eCnt));
        checkOutput({name, ".failAddr"}, oFail, 64'(eFirst));
      end
      @(negedge clk);
    end
    ifA.start = 1'b0;
    ifB.start = 1'b0;
  endtask

  task automatic resetMidRun();
    int kr;
    logic [63:0] oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail;
    clearFaults();
    stuck0 = 1'b1;
    kr = LEN_A + 1 + 41;
    applyStimulus(0);
    for (int k = 1; k < kr; k++) @(negedge clk);
    checkOutput("rst.preErrNonzero", 64'(ifA.err_cnt != 0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      sampleOutputs(0, oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail);
      checkOutput("rst.busy", oBusy, 64'(0));
      checkOutput("rst.addr", oAddr, 64'(0));
      checkOutput("rst.wr", oWr, 64'(0));
      checkOutput("rst.d", oD, 64'(0));
      checkOutput("rst.errCnt", oErr, 64'(0));
      checkOutput("rst.failAddr", oFail, 64'(0));
      checkOutput("rst.done", oDone, 64'(0));
      checkOutput("rst.pass", oPass, 64'(0));
      @(negedge clk);
    end
    clearFaults();
    tStartA = -100000;
    runMarch(0, 0, "afterRst");
  endtask

  initial begin
    int n, extra;
    logic [63:0] oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail;
    rst       = 1'b1;
    ifA.start = 1'b0;
    ifB.start = 1'b0;
    clearFaults();
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sampleOutputs(w, oAddr, oD, oWr, oBusy, oDone, oPass, oErr, oFail);
      checkOutput("reset.addr", oAddr, 64'(0));
      checkOutput("reset.d", oD, 64'(0));
      checkOutput("reset.wr", oWr, 64'(0));
      checkOutput("reset.busy", oBusy, 64'(0));
      checkOutput("reset.done", oDone, 64'(0));
      checkOutput("reset.pass", oPass, 64'(0));
      checkOutput("reset.errCnt", oErr, 64'(0));
      checkOutput("reset.failAddr", oFail, 64'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    runMarch(0, 0, "healthy");

    stuck0 = 1'b1;
    runMarch(0, 0, "stuckBit0");
    clearFaults();

    maskN[17] = 8'h04;
    runMarch(0, 0, "rdN17");
    clearFaults();

    maskP[LEN_A-1] = 8'h01;
    maskN[LEN_A-1] = 8'h80;
    runMarch(0, 0, "lastReads");
    clearFaults();

    runMarch(0, 100, "startWhileBusy");

    for (int it = 0; it < 6; it++) begin
      clearFaults();
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) maskP[$urandom_range(0, LEN_A-1)] = 8'($urandom_range(1, 255));
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) maskN[$urandom_range(0, LEN_A-1)] = 8'($urandom_range(1, 255));
      if (it == 2) extra = 4 * LEN_A + 2;
      else if (it == 4) extra = $urandom_range(1, 4 * LEN_A + 1);
      else extra = 0;
      runMarch(0, extra, "random");
    end
    clearFaults();

    resetMidRun();

    runMarch(1, 0, "len48");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
